// File: rtl/clock_edge_monitor.sv
// rtl/clock_edge_monitor.sv - slow-clock edge detector, period/high-time meter and loss monitor
module clock_edge_monitor #(
  parameter int unsigned          CNT_WIDTH = 28,
  parameter logic [CNT_WIDTH-1:0] TIMEOUT   = CNT_WIDTH'(1000)
) (
  input  logic                 in_clock,
  input  logic                 reset_n,
  input  logic                 sample_in,
  output logic                 rise_pulse,
  output logic                 fall_pulse,
  output logic [CNT_WIDTH-1:0] period_count,
  output logic [CNT_WIDTH-1:0] high_count,
  output logic                 measure_valid,
  output logic                 locked,
  output logic                 lost
);

  typedef enum logic [1:0] {IDLE, FIRST, LOCKED} state_t;

  localparam logic [CNT_WIDTH-1:0] ONE        = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_M1 = TIMEOUT - ONE;

  state_t               state;
  logic                 s1, s2, s3;
  logic [CNT_WIDTH-1:0] per_cnt;
  logic [CNT_WIDTH-1:0] gap_cnt;
  logic                 rise_det, fall_det, strobe, timeout;

  assign rise_det = s2 & ~s3;
  assign fall_det = ~s2 & s3;
  assign strobe   = rise_det | fall_det;
  // Only armed once a rise has been seen; a strobe in the same cycle takes priority.
  assign timeout  = !strobe && (state != IDLE) && (gap_cnt == TIMEOUT_M1);

  always_ff @(posedge in_clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      s1            <= 1'b0;
      s2            <= 1'b0;
      s3            <= 1'b0;
      rise_pulse    <= 1'b0;
      fall_pulse    <= 1'b0;
      per_cnt       <= '0;
      gap_cnt       <= '0;
      period_count  <= '0;
      high_count    <= '0;
      measure_valid <= 1'b0;
      locked        <= 1'b0;
      lost          <= 1'b0;
    end else begin
      s1            <= sample_in;
      s2            <= s1;
      s3            <= s2;
      rise_pulse    <= rise_det;
      fall_pulse    <= fall_det;
      measure_valid <= 1'b0;

      if (strobe)
        gap_cnt <= '0;
      else if (gap_cnt != TIMEOUT)
        gap_cnt <= gap_cnt + ONE;

      // per_cnt reads N when sampled N cycles after the last rise strobe.
      if (rise_det)
        per_cnt <= ONE;
      else if (per_cnt != CNT_MAX)
        per_cnt <= per_cnt + ONE;

      case (state)
        IDLE: begin
          if (rise_det) begin
            state <= FIRST;
            lost  <= 1'b0;
          end
        end
        FIRST: begin
          if (rise_det) begin
            state         <= LOCKED;
            period_count  <= per_cnt;
            measure_valid <= 1'b1;
            locked        <= 1'b1;
          end else if (timeout) begin
            state <= IDLE;
            lost  <= 1'b1;
          end
        end
        LOCKED: begin
          if (rise_det) begin
            period_count  <= per_cnt;
            measure_valid <= 1'b1;
          end else begin
            if (fall_det)
              high_count <= per_cnt;
            if (timeout) begin
              state  <= IDLE;
              lost   <= 1'b1;
              locked <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
